// File: rtl/vec_add_if.sv
// Host and memory-port signal bundle for vec_add_sequencer.
// Handshake: start is honoured only while busyb=1; busyb drops the cycle after accept and
// returns high once done has pulsed. There is no back-pressure on the memory port.
interface vec_add_if #(
  parameter int DW = 64,
  parameter int AW = 4
) ();
  logic          start;
  logic [AW-1:0] len;
  logic [AW-1:0] a_base;
  logic [AW-1:0] b_base;
  logic [AW-1:0] c_base;
  logic [AW-1:0] mem_addr;
  logic          mem_read_enb;
  logic [DW-1:0] mem_data;
  logic          mem_write_enb;
  logic [DW-1:0] res_data;
  logic          busyb;
  logic          done;
  logic          ovf;
  logic [2:0]    dbg_state;

  modport master (
    output start, len, a_base, b_base, c_base, mem_data,
    input  mem_addr, mem_read_enb, mem_write_enb, res_data, busyb, done, ovf, dbg_state
  );

  modport slave (
    input  start, len, a_base, b_base, c_base, mem_data,
    output mem_addr, mem_read_enb, mem_write_enb, res_data, busyb, done, ovf, dbg_state
  );
endinterface

// File: rtl/vec_add_sequencer.sv
// Sequences a single-port memory through read A, read B, add, write C for each element.
// All outputs are decoded from the state register and the job registers.
module vec_add_sequencer #(
  parameter int DW = 64,
  parameter int AW = 4
) (
  input  logic     clk,
  input  logic     rst,
  vec_add_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RA   = 3'd1,
    S_RB   = 3'd2,
    S_CAP  = 3'd3,
    S_WR   = 3'd4,
    S_FIN  = 3'd5
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] len_q, a_q, b_q, c_q, i_q;
  logic [AW-1:0] i_next;
  logic [DW-1:0] reg_a, reg_sum;
  logic          ovf_q;
  logic [DW:0]   sum_full;

  assign i_next   = i_q + 1'b1;
  assign sum_full = {1'b0, reg_a} + {1'b0, bus.mem_data};

  always_comb begin
    state_d           = state_q;
    bus.mem_addr      = '0;
    bus.mem_read_enb  = 1'b0;
    bus.mem_write_enb = 1'b0;
    bus.res_data      = '0;
    bus.done          = 1'b0;
    bus.busyb         = 1'b0;
    case (state_q)
      S_IDLE: begin
        bus.busyb = 1'b1;
        if (bus.start) begin
          state_d = (bus.len == '0) ? S_FIN : S_RA;
        end
      end
      S_RA: begin
        bus.mem_addr     = a_q + i_q;
        bus.mem_read_enb = 1'b1;
        state_d          = S_RB;
      end
      S_RB: begin
        bus.mem_addr     = b_q + i_q;
        bus.mem_read_enb = 1'b1;
        state_d          = S_CAP;
      end
      S_CAP: begin
        state_d = S_WR;
      end
      S_WR: begin
        bus.mem_addr      = c_q + i_q;
        bus.mem_write_enb = 1'b1;
        bus.res_data      = reg_sum;
        state_d           = (i_next == len_q) ? S_FIN : S_RA;
      end
      S_FIN: begin
        bus.done = 1'b1;
        state_d  = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      len_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= '0;
      i_q     <= '0;
      reg_a   <= '0;
      reg_sum <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        S_IDLE: begin
          // Snapshot the job; later changes on the inputs are not looked at.
          if (bus.start) begin
            len_q <= bus.len;
            a_q   <= bus.a_base;
            b_q   <= bus.b_base;
            c_q   <= bus.c_base;
            i_q   <= '0;
            ovf_q <= 1'b0;
          end
        end
        S_RB: begin
          reg_a <= bus.mem_data;
        end
        S_CAP: begin
          reg_sum <= sum_full[DW-1:0];
          ovf_q   <= ovf_q | sum_full[DW];
        end
        S_WR: begin
          i_q <= i_next;
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.ovf       = ovf_q;
  assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_vec_add_sequencer.sv
// Bench for vec_add_sequencer: 16-word memory model, sequential C=A+B reference, per-cycle strobe checks.
module tb_vec_add_sequencer;
  localparam int DW = 64;
  localparam int AW = 4;
  localparam int W  = AW + DW;

  logic clk = 1'b0;
  logic rst;
  logic load;
  always #5 clk = ~clk;

  vec_add_if #(.DW(DW), .AW(AW)) bus ();
  vec_add_sequencer #(.DW(DW), .AW(AW)) dut (.clk(clk), .rst(rst), .bus(bus));

  logic [DW-1:0] mem[16];
  logic [DW-1:0] init_mem[16];
  logic [DW-1:0] ref_mem[16];
  logic [W-1:0]  exp_q[$];
  logic          ovf_exp;
  int            checks = 0;
  int            errors = 0;

  // Memory with one-cycle read latency.
  always @(posedge clk) begin
    if (load) begin
      for (int j = 0; j < 16; j++) mem[j] <= init_mem[j];
    end else if (bus.mem_write_enb === 1'b1) begin
      mem[bus.mem_addr] <= bus.res_data;
    end
    if (bus.mem_read_enb === 1'b1) bus.mem_data <= mem[bus.mem_addr];
  end

  function automatic logic [DW-1:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  task automatic randomize_mem();
    for (int j = 0; j < 16; j++) init_mem[j] = rnd64();
  endtask

  task automatic load_mem();
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    for (int j = 0; j < 16; j++) ref_mem[j] = init_mem[j];
  endtask

  // Element-by-element C=A+B; an element only counts if its write lands before a reset.
  task automatic model(input int n, input logic [3:0] ab, input logic [3:0] bb,
                       input logic [3:0] cb, input int rst_cyc);
    logic [DW:0] s;
    logic [3:0]  ca;
    ovf_exp = 1'b0;
    for (int e = 0; e < n; e++) begin
      s  = {1'b0, ref_mem[ab + 4'(e)]} + {1'b0, ref_mem[bb + 4'(e)]};
      ca = cb + 4'(e);
      if (rst_cyc == 0 || 4 * e + 4 <= rst_cyc) begin
        exp_q.push_back({ca, s[DW-1:0]});
        ref_mem[ca] = s[DW-1:0];
        ovf_exp     = ovf_exp | s[DW];
      end
    end
  endtask

  // Called on a negedge with the DUT idle; returns on a negedge with the DUT idle.
  task automatic run_job(input int n, input logic [3:0] ab, input logic [3:0] bb,
                         input logic [3:0] cb, input int rst_cyc, input bit poke_start);
    int fin, ph, e;
    logic exp_rd, exp_wr, exp_done, exp_busyb;
    logic [3:0] ea;
    logic [W-1:0] want;
    model(n, ab, bb, cb, rst_cyc);
    bus.start  = 1'b1;
    bus.len    = 4'(n);
    bus.a_base = ab;
    bus.b_base = bb;
    bus.c_base = cb;
    @(posedge clk);
    fin = (n == 0) ? 1 : 4 * n + 1;
    for (int k = 1; k <= fin + 1; k++) begin
      @(negedge clk);
      exp_rd = 1'b0; exp_wr = 1'b0; ea = '0;
      exp_done  = (k == fin);
      exp_busyb = (k == fin + 1);
      if (k < fin) begin
        ph = (k - 1) % 4;
        e  = (k - 1) / 4;
        case (ph)
          0: begin exp_rd = 1'b1; ea = ab + 4'(e); end
          1: begin exp_rd = 1'b1; ea = bb + 4'(e); end
          3: exp_wr = 1'b1;
          default: ;
        endcase
      end
      checks++;
      if ({bus.mem_read_enb, bus.mem_write_enb, bus.done, bus.busyb} !==
          {exp_rd, exp_wr, exp_done, exp_busyb}) begin
        errors++;
        $display("FAIL strobes len=%0d cycle=%0d got rd/wr/done/busyb=%b%b%b%b want %b%b%b%b",
                 n, k, bus.mem_read_enb, bus.mem_write_enb, bus.done, bus.busyb,
                 exp_rd, exp_wr, exp_done, exp_busyb);
      end
      if (exp_rd) begin
        checks++;
        if (bus.mem_addr !== ea) begin
          errors++;
          $display("FAIL rd_addr len=%0d cycle=%0d got %0d want %0d", n, k, bus.mem_addr, ea);
        end
      end
      if (exp_wr) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL wr_sb len=%0d cycle=%0d unexpected write addr=%0d", n, k, bus.mem_addr);
        end else begin
          want = exp_q.pop_front();
          if ({bus.mem_addr, bus.res_data} !== want) begin
            errors++;
            $display("FAIL wr_data len=%0d cycle=%0d got addr=%0d data=%h want addr=%0d data=%h",
                     n, k, bus.mem_addr, bus.res_data, want[W-1:DW], want[DW-1:0]);
          end
        end
      end
      if (k == fin + 1) begin
        checks++;
        if (bus.ovf !== ovf_exp) begin
          errors++;
          $display("FAIL ovf len=%0d got %b want %b", n, bus.ovf, ovf_exp);
        end
      end
      if (k == 1) begin
        bus.start  = 1'b0;
        bus.len    = 4'($urandom_range(0, 15));
        bus.a_base = 4'($urandom_range(0, 15));
        bus.b_base = 4'($urandom_range(0, 15));
        bus.c_base = 4'($urandom_range(0, 15));
      end
      if (poke_start && k == 3) bus.start = 1'b1;
      if (poke_start && k == 4) bus.start = 1'b0;
      if (rst_cyc == k) begin
        rst = 1'b1;
        break;
      end
    end
    if (rst_cyc != 0) begin
      @(negedge clk);
      rst = 1'b0;
      for (int k = 0; k < 6; k++) begin
        checks++;
        if ({bus.mem_read_enb, bus.mem_write_enb, bus.done, bus.busyb} !== 4'b0001) begin
          errors++;
          $display("FAIL after_rst step=%0d got rd/wr/done/busyb=%b%b%b%b want 0001", k,
                   bus.mem_read_enb, bus.mem_write_enb, bus.done, bus.busyb);
        end
        @(negedge clk);
      end
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL missing_writes len=%0d got %0d pending want 0", n, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; load = 1'b0;
    bus.start = 1'b1; bus.len = '0;
    bus.a_base = '0; bus.b_base = '0; bus.c_base = '0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if ({bus.busyb, bus.done, bus.ovf, bus.mem_read_enb, bus.mem_write_enb} !== 5'b10000 ||
          bus.mem_addr !== 4'd0 || bus.res_data !== 64'd0) begin
        errors++;
        $display("FAIL reset_state got busyb/done/ovf/rd/wr=%b%b%b%b%b addr=%0d res=%h want 10000 0 0",
                 bus.busyb, bus.done, bus.ovf, bus.mem_read_enb, bus.mem_write_enb,
                 bus.mem_addr, bus.res_data);
      end
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus.done, bus.busyb} !== 2'b10) begin
      errors++;
      $display("FAIL start_after_reset got done/busyb=%b%b want 10", bus.done, bus.busyb);
    end
    bus.start = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus.done, bus.busyb} !== 2'b01) begin
      errors++;
      $display("FAIL idle_after_fin got done/busyb=%b%b want 01", bus.done, bus.busyb);
    end
  endtask

  task automatic test_single();
    randomize_mem();
    init_mem[0] = 64'd5; init_mem[1] = 64'd7;
    load_mem();
    run_job(1, 4'd0, 4'd1, 4'd2, 0, 1'b0);
    checks++;
    if (mem[2] !== 64'd12 || bus.ovf !== 1'b0) begin
      errors++;
      $display("FAIL single got mem2=%0d ovf=%b want 12 0", mem[2], bus.ovf);
    end
  endtask

  task automatic test_wrap();
    randomize_mem();
    init_mem[13] = 64'd1;  init_mem[14] = 64'd2;  init_mem[15] = 64'd3;
    init_mem[0]  = 64'd10; init_mem[1]  = 64'd20; init_mem[2]  = 64'd30;
    load_mem();
    run_job(3, 4'd13, 4'd0, 4'd4, 0, 1'b0);
    checks++;
    if (mem[4] !== 64'd11 || mem[5] !== 64'd22 || mem[6] !== 64'd33) begin
      errors++;
      $display("FAIL wrap got %0d %0d %0d want 11 22 33", mem[4], mem[5], mem[6]);
    end
  endtask

  task automatic test_ovf();
    logic [DW-1:0] ones;
    ones = '1;
    for (int j = 0; j < 16; j++) init_mem[j] = 64'(j);
    init_mem[0] = ones; init_mem[1] = 64'd1; init_mem[2] = 64'd1; init_mem[3] = 64'd1;
    load_mem();
    run_job(2, 4'd0, 4'd2, 4'd4, 0, 1'b0);
    checks++;
    if (mem[4] !== 64'd0 || mem[5] !== 64'd2 || bus.ovf !== 1'b1) begin
      errors++;
      $display("FAIL ovf_set got c0=%0d c1=%0d ovf=%b want 0 2 1", mem[4], mem[5], bus.ovf);
    end
    run_job(2, 4'd8, 4'd10, 4'd12, 0, 1'b0);
    checks++;
    if (bus.ovf !== 1'b0 || mem[12] !== 64'd18 || mem[13] !== 64'd20) begin
      errors++;
      $display("FAIL ovf_clear got ovf=%b c0=%0d c1=%0d want 0 18 20", bus.ovf, mem[12], mem[13]);
    end
  endtask

  task automatic test_len0_and_ignore();
    randomize_mem();
    load_mem();
    run_job(0, 4'd3, 4'd4, 4'd5, 0, 1'b0);
    run_job(4, 4'd2, 4'd9, 4'd14, 0, 1'b1);
  endtask

  task automatic test_reset_mid();
    randomize_mem();
    load_mem();
    run_job(4, 4'd0, 4'd4, 4'd8, 6, 1'b0);
    run_job(3, 4'd1, 4'd5, 4'd10, 0, 1'b0);
  endtask

  task automatic test_back_to_back();
    int n;
    randomize_mem();
    load_mem();
    for (int t = 0; t < 20; t++) begin
      n = $urandom_range(0, 15);
      run_job(n, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
              4'($urandom_range(0, 15)), 0, (n > 0) && ($urandom_range(0, 1) == 1));
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_wrap();
    test_ovf();
    test_len0_and_ignore();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/vec_add_sequencer.md
# vec_add_sequencer

Controller that sequences a single-port 64-bit memory and an internal adder to compute C[i] = A[i] + B[i] for a vector of up to 15 elements. It owns the memory port for the duration of a job and reports progress through the `busyb`/`done` status pair used across the accelerator. A host starts a job with one handshake; the block then performs every read, add and write itself.

## Interface
Parameters:
- `DW`, 64, data word width
- `AW`, 4, memory address width; all address arithmetic is modulo 2^AW

Ports:
- `clk`  in  1  rising-edge clock
- `rst`  in  1  synchronous, active-high reset
- `start`  in  1  job request, sampled only in IDLE
- `len`  in  AW  element count (0..15)
- `a_base`, `b_base`, `c_base`  in  AW each  base addresses of the A, B and C vectors
- `mem_addr`  out  AW  memory address
- `mem_read_enb`  out  1  read strobe; data returns on `mem_data` one cycle later
- `mem_data`  in  DW  read data
- `mem_write_enb`  out  1  write strobe, active-high, valid with `mem_addr`/`res_data`
- `res_data`  out  DW  write data
- `busyb`  out  1  1 = idle/ready, 0 = job in progress
- `done`  out  1  one-cycle completion pulse
- `ovf`  out  1  sticky: at least one element sum carried out of DW bits

## Operation
- States: IDLE, RA, RB, CAP, WR, FIN.
- IDLE:
  - `busyb`=1.
  - When `start`=1: latch `len`, the three bases, i=0, and clear `ovf`.
  - If latched len=0, go to FIN; otherwise go to RA.
- RA: `mem_addr`=a_base+i, `mem_read_enb`=1 → RB.
- RB: capture `mem_data` into reg_a; `mem_addr`=b_base+i, `mem_read_enb`=1 → CAP.
- CAP: capture reg_a+`mem_data` into reg_sum (DW bits, modulo 2^DW); carry-out ORs into `ovf` → WR.
- WR:
  - `mem_addr`=c_base+i, `mem_write_enb`=1, `res_data`=reg_sum.
  - Increment i. If the new i equals len, go to FIN; otherwise go to RA.
- FIN: `done`=1 → IDLE.
- Outputs are Moore-decoded from state and registers. Outside the cycles listed above, `mem_read_enb`=0, `mem_write_enb`=0, `done`=0, `busyb`=0.
- `start` outside IDLE is ignored; it is not queued.
- Job parameters are snapshotted at accept. Input changes mid-job have no effect.
- Address wrap: base+i computed in AW bits (e.g. a_base=14, i=3 → address 1).
- Overlapping A/B/C regions are legal. Element i is written after element i's reads and before element i+1's reads, so in-place C=A works.

## Timing
- Reset values (cycle after `rst`=1): state=IDLE, `busyb`=1, `done`=0, `ovf`=0, `mem_read_enb`=0, `mem_write_enb`=0, `mem_addr`=0, `res_data`=0.
- `rst` takes priority over everything, including mid-job. The partial job is abandoned, no further strobes are issued, and `done` is not pulsed.
- Cycle numbering: `start` sampled in cycle 0.
  - len=0: FIN in cycle 1.
  - len=N≥1: element k occupies cycles 4k+1..4k+4 (RA, RB, CAP, WR). FIN is in cycle 4N+1; IDLE with `busyb`=1 is in cycle 4N+2.
- `busyb` goes low in cycle 1 and stays low through FIN.
- A new `start` is accepted no earlier than cycle 4N+2 (back-to-back jobs allowed).
- At most one of `mem_read_enb`/`mem_write_enb` is high in any cycle.
- Memory read latency is fixed at 1 cycle; no wait states.

## Test plan
- Reset with `start` held high: `busyb`=1, `done`=0, no strobes while `rst`=1. With `rst` low and `start` still high, the job is accepted on the next cycle.
- len=1, a_base=0, b_base=1, c_base=2, mem[0]=5, mem[1]=7 → one write of 12 to address 2 in cycle 4, `done` in cycle 5, `ovf`=0.
- len=3, a_base=13, b_base=0, c_base=4, A={1,2,3}, B={10,20,30} → reads at 13,0,14,1,15,2 and writes 11,22,33 to 4,5,6; `done` in cycle 13.
- len=2, A={2^64−1, 1}, B={1, 1} → C={0, 2}; `ovf`=1 after job. A following job with no carry → `ovf`=0.
- len=0 → `done` in cycle 1, zero memory strobes. `start` pulsed during a len=4 job is ignored, with exactly 4 writes.
- `rst` asserted in cycle 6 of a len=4 job → IDLE next cycle, no `done`, no write strobe after reset. A fresh job then completes normally.
